// File: rtl/multiphase_clk_gen_if.sv
// Control/status bundle for multiphase_clk_gen; MULTIPHASE_TICK_EN adds tick_out.
// div_load is a one-cycle request strobe with no back-pressure; div_ack pulses once when that divider takes effect.
interface multiphase_clk_gen_if #(
    parameter int NUM_PHASES = 5,
    parameter int DIV_W      = 16
);
    localparam int SLOT_W = $clog2(NUM_PHASES);

    logic                  en;
    logic [DIV_W-1:0]      div_in;
    logic                  div_load;
    logic                  div_ack;
    logic [NUM_PHASES-1:0] phase_out;
    logic [SLOT_W-1:0]     slot;
    logic                  locked;
    logic [1:0]            state;
`ifdef MULTIPHASE_TICK_EN
    logic [NUM_PHASES-1:0] tick_out;
`endif

    modport master (
        output en, div_in, div_load,
        input  div_ack, phase_out, slot, locked, state
`ifdef MULTIPHASE_TICK_EN
        , input tick_out
`endif
    );

    modport slave (
        input  en, div_in, div_load,
        output div_ack, phase_out, slot, locked, state
`ifdef MULTIPHASE_TICK_EN
        , output tick_out
`endif
    );
endinterface

// File: rtl/multiphase_clk_gen.sv
// Counter-based multiphase generator: NUM_PHASES evenly spaced phases, runtime divider reload, lock flag.
// Optional macro MULTIPHASE_TICK_EN adds per-phase first-cycle tick pulses.
module multiphase_clk_gen #(
    parameter int NUM_PHASES   = 5,
    parameter int DIV_W        = 16,
    parameter int DEFAULT_DIV  = 10,
    parameter int LOCK_PERIODS = 4
) (
    input  logic                 clk_in,
    input  logic                 reset,
    multiphase_clk_gen_if.slave  bus
);
    localparam int SLOT_W = $clog2(NUM_PHASES);
    localparam int HIGH   = (NUM_PHASES + 1) / 2;
    localparam int PER_W  = $clog2(LOCK_PERIODS + 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_PHASES - 1);
    localparam logic [PER_W-1:0]  LAST_PER  = PER_W'(LOCK_PERIODS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, LOCK = 2'd2} state_t;

    state_t                state;
    logic [DIV_W-1:0]      cnt;
    logic [DIV_W-1:0]      div_reg;
    logic [DIV_W-1:0]      pend_div;
    logic                  pending;
    logic [SLOT_W-1:0]     slot;
    logic [PER_W-1:0]      periods;
    logic [NUM_PHASES-1:0] phase;
    logic                  locked;
    logic                  div_ack;

    logic                  wrap;
    logic                  boundary;
    logic [DIV_W-1:0]      cnt_nxt;
    logic [SLOT_W-1:0]     slot_nxt;
    logic [DIV_W-1:0]      din_clamped;

    // Phase k is high while the slot sits in k .. k+HIGH-1 (mod NUM_PHASES).
    function automatic logic [NUM_PHASES-1:0] pattern(input logic [SLOT_W-1:0] s);
        logic [NUM_PHASES-1:0] p;
        int d;
        p = '0;
        for (int k = 0; k < NUM_PHASES; k++) begin
            d    = (int'(s) + NUM_PHASES - k) % NUM_PHASES;
            p[k] = (d < HIGH);
        end
        return p;
    endfunction

    always_comb begin
        wrap        = (cnt >= div_reg - DIV_W'(1));
        boundary    = wrap && (slot == LAST_SLOT);
        cnt_nxt     = wrap ? '0 : cnt + DIV_W'(1);
        slot_nxt    = slot;
        if (wrap) begin
            slot_nxt = (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
        end
        din_clamped = (bus.div_in == '0) ? DIV_W'(1) : bus.div_in;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            div_reg  <= DIV_W'(DEFAULT_DIV);
            pend_div <= '0;
            pending  <= 1'b0;
            slot     <= '0;
            periods  <= '0;
            phase    <= '0;
            locked   <= 1'b0;
            div_ack  <= 1'b0;
        end else begin
            div_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.div_load) begin
                        div_reg <= din_clamped;
                        div_ack <= 1'b1;
                    end
                    if (bus.en) begin
                        state <= ACQ;
                        cnt   <= '0;
                        slot  <= '0;
                        phase <= pattern('0);
                    end
                end
                ACQ, LOCK: begin
                    if (!bus.en) begin
                        // Disabling drops any divider still waiting for a boundary.
                        state   <= IDLE;
                        cnt     <= '0;
                        slot    <= '0;
                        phase   <= '0;
                        locked  <= 1'b0;
                        periods <= '0;
                        pending <= 1'b0;
                    end else begin
                        cnt   <= cnt_nxt;
                        slot  <= slot_nxt;
                        phase <= pattern(slot_nxt);
                        if (boundary) begin
                            if (pending) begin
                                div_reg <= pend_div;
                                div_ack <= 1'b1;
                                pending <= 1'b0;
                                periods <= '0;
                                state   <= ACQ;
                                locked  <= 1'b0;
                            end else if (state == ACQ) begin
                                if (periods == LAST_PER) begin
                                    state   <= LOCK;
                                    locked  <= 1'b1;
                                    periods <= '0;
                                end else begin
                                    periods <= periods + PER_W'(1);
                                end
                            end
                        end
                        // Placed last so a strobe on an apply edge stays pending for the next boundary.
                        if (bus.div_load) begin
                            pend_div <= din_clamped;
                            pending  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MULTIPHASE_TICK_EN
    logic [NUM_PHASES-1:0] tick;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            tick <= '0;
        end else if (!bus.en || (state != IDLE && state != ACQ && state != LOCK)) begin
            tick <= '0;
        end else if (state == IDLE) begin
            tick <= NUM_PHASES'(1);
        end else begin
            tick <= (cnt_nxt == '0) ? (NUM_PHASES'(1) << slot_nxt) : '0;
        end
    end

    assign bus.tick_out = tick;
`endif

    assign bus.div_ack   = div_ack;
    assign bus.phase_out = phase;
    assign bus.slot      = slot;
    assign bus.locked    = locked;
    assign bus.state     = state;
endmodule

// File: tb/tb_multiphase_clk_gen.sv
// Self-checking bench for multiphase_clk_gen: elapsed-time reference model plus scenario checks.
`timescale 1ns/1ps
module tb_multiphase_clk_gen;
    localparam int N    = 5;
    localparam int DW   = 16;
    localparam int DEF  = 10;
    localparam int LP   = 4;
    localparam int SW   = $clog2(N);
    localparam int HIGH = (N + 1) / 2;
`ifdef MULTIPHASE_TICK_EN
    localparam int W = 2 + SW + 2 * N;
`else
    localparam int W = 2 + SW + N;
`endif

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    logic reset;
    always #5 clk_in = ~clk_in;

    multiphase_clk_gen_if #(.NUM_PHASES(N), .DIV_W(DW)) bus ();

    multiphase_clk_gen #(
        .NUM_PHASES(N), .DIV_W(DW), .DEFAULT_DIV(DEF), .LOCK_PERIODS(LP)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    logic [W-1:0] obs_vec;
`ifdef MULTIPHASE_TICK_EN
    assign obs_vec = {bus.tick_out, bus.div_ack, bus.locked, bus.slot, bus.phase_out};
`else
    assign obs_vec = {bus.div_ack, bus.locked, bus.slot, bus.phase_out};
`endif

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;
    int errors = 0;
    int checks = 0;

    // Reference model: t = cycles since the current run segment started at slot 0.
    bit m_run;
    bit m_pend;
    bit m_ack;
    int m_div;
    int m_pend_div;
    int m_t;

    function automatic void model_reset();
        m_run = 0; m_pend = 0; m_ack = 0;
        m_div = DEF; m_pend_div = 0; m_t = 0;
    endfunction

    function automatic logic [W-1:0] model_vec();
        logic [N-1:0] ph;
        logic [N-1:0] tk;
        logic lk;
        int s;
        ph = '0; tk = '0; lk = 1'b0; s = 0;
        if (m_run) begin
            s  = (m_t / m_div) % N;
            lk = (m_t >= LP * N * m_div);
            for (int k = 0; k < N; k++) begin
                ph[k] = ((((s - k) % N) + N) % N) < HIGH;
                tk[k] = ((m_t % m_div) == 0) && (s == k);
            end
        end
`ifdef MULTIPHASE_TICK_EN
        return {tk, m_ack, lk, SW'(s), ph};
`else
        return {m_ack, lk, SW'(s), ph};
`endif
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic en_v, input logic ld_v, input logic [DW-1:0] din_v);
        int dclamp;
        bus.en = en_v; bus.div_load = ld_v; bus.div_in = din_v;
        @(posedge clk_in);
        dclamp = (din_v == '0) ? 1 : int'(din_v);
        m_ack = 0;
        if (!m_run) begin
            if (ld_v) begin m_div = dclamp; m_ack = 1; end
            if (en_v) begin m_run = 1; m_t = 0; end
        end else if (!en_v) begin
            m_run = 0; m_pend = 0;
        end else begin
            m_t++;
            if (m_pend && (m_t % (N * m_div) == 0)) begin
                m_div = m_pend_div; m_pend = 0; m_ack = 1; m_t = 0;
            end
            if (ld_v) begin m_pend = 1; m_pend_div = dclamp; end
        end
        exp_q.push_back(model_vec());
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; bus.en = 1'b0; bus.div_load = 1'b0; bus.div_in = '0;
        model_reset(); exp_q.delete();
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if (obs_vec !== '0) begin errors++; $display("FAIL reset_state got=%h want=0", obs_vec); end
        reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            drive(1'b1, 1'b0, '0);
            exp_v = exp_q.pop_front(); checks++;
            if (obs_vec !== exp_v) begin errors++; $display("FAIL reset_run c=%0d got=%h want=%h", c, obs_vec, exp_v); end
            if (c == 11) begin
                checks++;
                if (bus.slot !== SW'(1)) begin errors++; $display("FAIL default_div_slot got=%0d want=1", bus.slot); end
            end
        end
        drive(1'b0, 1'b0, '0);
        exp_v = exp_q.pop_front(); checks++;
        if (obs_vec !== exp_v) begin errors++; $display("FAIL reset_idle got=%h want=%h", obs_vec, exp_v); end
    endtask

    task automatic test_defaults();
        drive(1'b0, 1'b1, DW'(2));
        checks++;
        if (bus.div_ack !== 1'b1) begin errors++; $display("FAIL idle_load_ack got=%b want=1", bus.div_ack); end
        exp_v = exp_q.pop_front(); checks++;
        if (obs_vec !== exp_v) begin errors++; $display("FAIL idle_load got=%h want=%h", obs_vec, exp_v); end
        for (int c = 1; c <= 45; c++) begin
            drive(1'b1, 1'b0, '0);
            exp_v = exp_q.pop_front(); checks++;
            if (obs_vec !== exp_v) begin errors++; $display("FAIL defaults c=%0d got=%h want=%h", c, obs_vec, exp_v); end
            // phase k is high in slots k..k+2, so slot 0 -> phases 0,3,4 and slot 1 -> phases 0,1,4
            if (c == 1) begin
                checks++;
                if (bus.slot !== SW'(0) || bus.phase_out !== 5'b11001) begin
                    errors++; $display("FAIL first_slot got=%0d/%b want=0/11001", bus.slot, bus.phase_out);
                end
            end
            if (c == 3) begin
                checks++;
                if (bus.slot !== SW'(1) || bus.phase_out !== 5'b10011) begin
                    errors++; $display("FAIL second_slot got=%0d/%b want=1/10011", bus.slot, bus.phase_out);
                end
            end
            if (c == 40 || c == 41) begin
                checks++;
                if (bus.locked !== (c == 41)) begin
                    errors++; $display("FAIL lock_edge c=%0d got=%b want=%b", c, bus.locked, c == 41);
                end
            end
        end
    endtask

    task automatic test_reload();
        int ack_c = -1;
        int lock_c = -1;
        drive(1'b1, 1'b1, DW'(3));
        exp_v = exp_q.pop_front(); checks++;
        if (obs_vec !== exp_v) begin errors++; $display("FAIL reload_strobe got=%h want=%h", obs_vec, exp_v); end
        for (int c = 1; c <= 200 && lock_c < 0; c++) begin
            drive(1'b1, 1'b0, '0);
            exp_v = exp_q.pop_front(); checks++;
            if (obs_vec !== exp_v) begin errors++; $display("FAIL reload c=%0d got=%h want=%h", c, obs_vec, exp_v); end
            if (bus.div_ack === 1'b1 && ack_c < 0) begin
                ack_c = c;
                checks++;
                if (bus.locked !== 1'b0) begin errors++; $display("FAIL reload_unlock got=%b want=0", bus.locked); end
            end else if (ack_c >= 0 && bus.locked === 1'b1) begin
                lock_c = c;
            end
        end
        checks++;
        if (ack_c != 5) begin errors++; $display("FAIL reload_ack_cycle got=%0d want=5", ack_c); end
        checks++;
        if (lock_c - ack_c != 60) begin errors++; $display("FAIL relock_delay got=%0d want=60", lock_c - ack_c); end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        int ack_c = -1;
        drive(1'b1, 1'b1, DW'(4));
        exp_v = exp_q.pop_front(); checks++;
        if (obs_vec !== exp_v) begin errors++; $display("FAIL b2b_first got=%h want=%h", obs_vec, exp_v); end
        drive(1'b1, 1'b1, DW'(6));
        exp_v = exp_q.pop_front(); checks++;
        if (obs_vec !== exp_v) begin errors++; $display("FAIL b2b_second got=%h want=%h", obs_vec, exp_v); end
        for (int c = 1; c <= 140; c++) begin
            drive(1'b1, 1'b0, '0);
            exp_v = exp_q.pop_front(); checks++;
            if (obs_vec !== exp_v) begin errors++; $display("FAIL b2b c=%0d got=%h want=%h", c, obs_vec, exp_v); end
            if (bus.div_ack === 1'b1) begin acks++; ack_c = c; end
        end
        checks++;
        if (acks != 1 || ack_c != 13) begin errors++; $display("FAIL b2b_acks got=%0d@%0d want=1@13", acks, ack_c); end
        checks++;
        if (bus.locked !== 1'b1) begin errors++; $display("FAIL b2b_relock got=%b want=1", bus.locked); end
    endtask

    task automatic test_en_drop();
        int lock_c = -1;
        drive(1'b0, 1'b0, '0);
        exp_v = exp_q.pop_front(); checks++;
        if (obs_vec !== exp_v) begin errors++; $display("FAIL en_drop got=%h want=%h", obs_vec, exp_v); end
        checks++;
        if (bus.phase_out !== '0 || bus.locked !== 1'b0 || bus.slot !== '0) begin
            errors++; $display("FAIL en_drop_clear got=%b/%b/%0d want=0/0/0", bus.phase_out, bus.locked, bus.slot);
        end
        for (int c = 1; c <= 125; c++) begin
            drive(1'b1, 1'b0, '0);
            exp_v = exp_q.pop_front(); checks++;
            if (obs_vec !== exp_v) begin errors++; $display("FAIL reenable c=%0d got=%h want=%h", c, obs_vec, exp_v); end
            if (bus.locked === 1'b1 && lock_c < 0) lock_c = c;
        end
        checks++;
        if (lock_c != 121) begin errors++; $display("FAIL reenable_lock got=%0d want=121", lock_c); end
    endtask

    task automatic test_div_zero();
        int highs = 0;
        drive(1'b0, 1'b0, '0);
        exp_v = exp_q.pop_front(); checks++;
        if (obs_vec !== exp_v) begin errors++; $display("FAIL dz_idle got=%h want=%h", obs_vec, exp_v); end
        drive(1'b0, 1'b1, '0);
        checks++;
        if (bus.div_ack !== 1'b1) begin errors++; $display("FAIL dz_ack got=%b want=1", bus.div_ack); end
        exp_v = exp_q.pop_front(); checks++;
        if (obs_vec !== exp_v) begin errors++; $display("FAIL dz_load got=%h want=%h", obs_vec, exp_v); end
        for (int c = 1; c <= 25; c++) begin
            drive(1'b1, 1'b0, '0);
            exp_v = exp_q.pop_front(); checks++;
            if (obs_vec !== exp_v) begin errors++; $display("FAIL dz c=%0d got=%h want=%h", c, obs_vec, exp_v); end
            if (bus.phase_out[0] === 1'b1) highs++;
        end
        checks++;
        if (highs != 15) begin errors++; $display("FAIL dz_duty got=%0d want=15", highs); end
    endtask

    task automatic test_reset_async();
        for (int c = 1; c <= 7; c++) begin
            drive(1'b1, (c == 4), DW'(3));
            exp_v = exp_q.pop_front(); checks++;
            if (obs_vec !== exp_v) begin errors++; $display("FAIL pre_reset c=%0d got=%h want=%h", c, obs_vec, exp_v); end
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs_vec !== '0) begin errors++; $display("FAIL async_reset got=%h want=0", obs_vec); end
        model_reset(); exp_q.delete();
        @(negedge clk_in);
        reset = 1'b0;
        for (int c = 1; c <= 55; c++) begin
            drive(1'b1, 1'b0, '0);
            exp_v = exp_q.pop_front(); checks++;
            if (obs_vec !== exp_v) begin errors++; $display("FAIL post_reset c=%0d got=%h want=%h", c, obs_vec, exp_v); end
            if (c == 10 || c == 11) begin
                checks++;
                if (bus.slot !== SW'(c - 10)) begin errors++; $display("FAIL post_reset_slot c=%0d got=%0d want=%0d", c, bus.slot, c - 10); end
            end
        end
    endtask

    task automatic test_random();
        logic en_v;
        logic ld_v;
        logic [DW-1:0] din_v;
        for (int c = 1; c <= 1500; c++) begin
            en_v  = ($urandom_range(0, 99) != 0);
            ld_v  = ($urandom_range(0, 29) == 0);
            din_v = DW'($urandom_range(0, 3));
            drive(en_v, ld_v, din_v);
            exp_v = exp_q.pop_front(); checks++;
            if (obs_vec !== exp_v) begin errors++; $display("FAIL random c=%0d got=%h want=%h", c, obs_vec, exp_v); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_defaults();
        test_reload();
        test_back_to_back();
        test_en_drop();
        test_div_zero();
        test_reset_async();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
